// File: rtl/flappy_score_display_if.sv
// Connects the game-logic pulses to the score/display block and returns the
// display, score and phase outputs. The game logic is the master; the score
// block is the slave.
interface flappy_score_display_if #(
    parameter int DIGITS  = 3,
    parameter int NUM_HEX = 6
);
    logic                   start;
    logic                   point;
    logic                   collision;
    logic                   clear_high;
    logic [7*NUM_HEX-1:0]   hex_out;
    logic [4*DIGITS-1:0]    score_bcd;
    logic [4*DIGITS-1:0]    high_bcd;
    logic                   new_high;
    logic [1:0]             phase;

    modport master (
        output start, point, collision, clear_high,
        input  hex_out, score_bcd, high_bcd, new_high, phase
    );

    modport slave (
        input  start, point, collision, clear_high,
        output hex_out, score_bcd, high_bcd, new_high, phase
    );
endinterface

// File: rtl/flappy_score_display.sv
// Game score block for the seven-segment bank: keeps a saturating BCD score
// and a persistent high score, tracks the IDLE/PLAY/OVER game phase, and
// renders either the score or a text message (blinking with the score at the
// end of a game) onto active-low gfedcba digits.
module flappy_score_display #(
    parameter int DIGITS       = 3,
    parameter int NUM_HEX      = 6,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic                 clk,
    input  logic                 reset,
    flappy_score_display_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MSG_START = 2'd0,
        MSG_LOSER = 2'd1,
        MSG_BEST  = 2'd2
    } msg_e;

    localparam int                  CNT_W     = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_TERM  = CNT_W'(BLINK_CYCLES - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [6:0]          SEG_BLANK = 7'b1111111;

    state_e              state_q, state_d;
    logic [4*DIGITS-1:0] score_q, score_d;
    logic [4*DIGITS-1:0] high_q, high_d;
    logic                new_high_q, new_high_d;
    logic [CNT_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                blink_ph_q, blink_ph_d;
    logic [7*NUM_HEX-1:0] hex_c;

    // BCD increment with nibble ripple; an all-nines score stays put.
    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                carry;
        r     = v;
        carry = 1'b1;
        if (v != ALL_NINES) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (v[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Decimal digit to segments; anything outside 0-9 is blanked.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Character p (0 = leftmost) of a message; blank past the end of the text.
    function automatic logic [6:0] msg_char(input msg_e sel, input int p);
        logic [6:0] c;
        c = SEG_BLANK;
        case (sel)
            MSG_START: case (p)
                0: c = 7'b0010010;
                1: c = 7'b0000111;
                2: c = 7'b0001000;
                3: c = 7'b0101111;
                4: c = 7'b0000111;
                default: c = SEG_BLANK;
            endcase
            MSG_LOSER: case (p)
                0: c = 7'b1000111;
                1: c = 7'b1000000;
                2: c = 7'b0010010;
                3: c = 7'b0000110;
                4: c = 7'b0101111;
                default: c = SEG_BLANK;
            endcase
            MSG_BEST: case (p)
                0: c = 7'b0000011;
                1: c = 7'b0000110;
                2: c = 7'b0010010;
                3: c = 7'b0000111;
                default: c = SEG_BLANK;
            endcase
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

    // Next-state logic for game phase, scores and the end-of-game blink timer.
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        high_d      = high_q;
        new_high_d  = new_high_q;
        blink_cnt_d = '0;
        blink_ph_d  = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d    = PLAY;
                    score_d    = '0;
                    new_high_d = 1'b0;
                end
                if (bus.clear_high) begin
                    high_d = '0;
                end
            end
            PLAY: begin
                if (bus.collision) begin
                    state_d = OVER;
                    if (score_q > high_q) begin
                        high_d     = score_q;
                        new_high_d = 1'b1;
                    end else begin
                        new_high_d = 1'b0;
                    end
                end else if (bus.point) begin
                    score_d = bcd_inc(score_q);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q == OVER && state_d == OVER) begin
            if (blink_cnt_q == CNT_TERM) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
                blink_ph_d  = blink_ph_q;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            score_q     <= '0;
            high_q      <= '0;
            new_high_q  <= 1'b0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            high_q      <= high_d;
            new_high_q  <= new_high_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    // Render either the score (leading zeros blanked) or a left-aligned message.
    always_comb begin
        logic show_score;
        logic seen;
        msg_e sel;
        hex_c      = '1;
        seen       = 1'b0;
        show_score = (state_q == PLAY) || (state_q == OVER && blink_ph_q);
        sel        = (state_q == OVER) ? (new_high_q ? MSG_BEST : MSG_LOSER) : MSG_START;
        if (show_score) begin
            for (int i = DIGITS - 1; i >= 0; i--) begin
                if (score_q[4*i +: 4] != 4'd0) begin
                    seen = 1'b1;
                end
                if (seen || i == 0) begin
                    hex_c[7*(NUM_HEX-DIGITS+i) +: 7] = seg_digit(score_q[4*i +: 4]);
                end
            end
        end else begin
            for (int p = 0; p < NUM_HEX; p++) begin
                hex_c[7*(NUM_HEX-1-p) +: 7] = msg_char(sel, p);
            end
        end
    end

    assign bus.hex_out   = hex_c;
    assign bus.score_bcd = score_q;
    assign bus.high_bcd  = high_q;
    assign bus.new_high  = new_high_q;
    assign bus.phase     = state_q;

endmodule

// File: tb/tb_flappy_score_display.sv
// Directed bench for flappy_score_display with DIGITS=3, NUM_HEX=6 and a
// short blink period so the end-of-game blink can be observed.
module tb_flappy_score_display;

    localparam int DIGITS       = 3;
    localparam int NUM_HEX      = 6;
    localparam int BLINK_CYCLES = 4;

    localparam logic [6:0] BL  = 7'b1111111;
    localparam logic [6:0] D0  = 7'b1000000;
    localparam logic [6:0] D1  = 7'b1111001;
    localparam logic [6:0] D2  = 7'b0100100;
    localparam logic [6:0] D3  = 7'b0110000;
    localparam logic [6:0] D4  = 7'b0011001;
    localparam logic [6:0] D7  = 7'b1111000;
    localparam logic [6:0] D8  = 7'b0000000;
    localparam logic [6:0] D9  = 7'b0010000;
    localparam logic [6:0] C_S = 7'b0010010;
    localparam logic [6:0] C_T = 7'b0000111;
    localparam logic [6:0] C_A = 7'b0001000;
    localparam logic [6:0] C_R = 7'b0101111;
    localparam logic [6:0] C_L = 7'b1000111;
    localparam logic [6:0] C_O = 7'b1000000;
    localparam logic [6:0] C_E = 7'b0000110;
    localparam logic [6:0] C_B = 7'b0000011;

    localparam logic [41:0] START_MSG = {C_S, C_T, C_A, C_R, C_T, BL};
    localparam logic [41:0] LOSER_MSG = {C_L, C_O, C_S, C_E, C_R, BL};
    localparam logic [41:0] BEST_MSG  = {C_B, C_E, C_S, C_T, BL, BL};
    localparam logic [41:0] SC0       = {BL, BL, D0, BL, BL, BL};
    localparam logic [41:0] SC1       = {BL, BL, D1, BL, BL, BL};
    localparam logic [41:0] SC2       = {BL, BL, D2, BL, BL, BL};

    typedef struct {
        logic        start;
        logic        point;
        logic        collision;
        logic        clear_high;
        logic [1:0]  exp_phase;
        logic [11:0] exp_score;
        logic [11:0] exp_high;
        logic        exp_new_high;
        logic [41:0] exp_hex;
    } vec_t;

    logic clk;
    logic reset;
    int   num_checks;
    int   num_fail;
    vec_t vecs [12];

    flappy_score_display_if #(.DIGITS(DIGITS), .NUM_HEX(NUM_HEX)) bus ();

    flappy_score_display #(
        .DIGITS(DIGITS),
        .NUM_HEX(NUM_HEX),
        .BLINK_CYCLES(BLINK_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic c, input logic ch);
        bus.start      = s;
        bus.point      = p;
        bus.collision  = c;
        bus.clear_high = ch;
        tick();
        bus.start      = 1'b0;
        bus.point      = 1'b0;
        bus.collision  = 1'b0;
        bus.clear_high = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [1:0] ph, input logic [11:0] sc,
                            input logic [11:0] hi, input logic nh, input logic [41:0] hx);
        checkOutput({tag, " phase"},    64'(bus.phase),     64'(ph));
        checkOutput({tag, " score"},    64'(bus.score_bcd), 64'(sc));
        checkOutput({tag, " high"},     64'(bus.high_bcd),  64'(hi));
        checkOutput({tag, " new_high"}, 64'(bus.new_high),  64'(nh));
        checkOutput({tag, " hex"},      64'(bus.hex_out),   64'(hx));
    endtask

    task automatic resetDut();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic points(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        num_checks     = 0;
        num_fail       = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.point      = 1'b0;
        bus.collision  = 1'b0;
        bus.clear_high = 1'b0;

        //                start point coll clr  phase score   high    nh    hex
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 12'h000, 12'h000, 1'b0, START_MSG};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 12'h000, 12'h000, 1'b0, START_MSG};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 12'h000, 12'h000, 1'b0, START_MSG};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 12'h000, 12'h000, 1'b0, SC0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 12'h001, 12'h000, 1'b0, SC1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 12'h002, 12'h000, 1'b0, SC2};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 12'h002, 12'h000, 1'b0, SC2};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 12'h002, 12'h002, 1'b1, BEST_MSG};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 12'h002, 12'h002, 1'b1, BEST_MSG};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 12'h002, 12'h000, 1'b1, BEST_MSG};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 12'h000, 12'h000, 1'b0, SC0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 12'h000, 12'h000, 1'b0, LOSER_MSG};

        // Reset state, visible while reset is still held.
        #2;
        checkAll("reset", 2'd0, 12'h000, 12'h000, 1'b0, START_MSG);
        resetDut();

        $display("[TB] table-driven vectors");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].start, vecs[i].point, vecs[i].collision, vecs[i].clear_high);
            checkAll($sformatf("vec%0d", i), vecs[i].exp_phase, vecs[i].exp_score,
                     vecs[i].exp_high, vecs[i].exp_new_high, vecs[i].exp_hex);
        end

        $display("[TB] score counting and leading-zero blanking");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        points(7);
        checkOutput("score7 value", 64'(bus.score_bcd), 64'(12'h007));
        checkOutput("score7 hex",   64'(bus.hex_out),   64'({BL, BL, D7, BL, BL, BL}));
        points(3);
        checkOutput("score10 hex",  64'(bus.hex_out),   64'({BL, D1, D0, BL, BL, BL}));
        points(113);
        checkOutput("score123 value", 64'(bus.score_bcd), 64'(12'h123));
        checkOutput("score123 hex",   64'(bus.hex_out),   64'({D1, D2, D3, BL, BL, BL}));

        $display("[TB] saturation");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        points(998);
        checkOutput("score998 value", 64'(bus.score_bcd), 64'(12'h998));
        checkOutput("score998 hex",   64'(bus.hex_out),   64'({D9, D9, D8, BL, BL, BL}));
        points(3);
        checkOutput("saturate value", 64'(bus.score_bcd), 64'(12'h999));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkAll("sat collision", 2'd2, 12'h999, 12'h999, 1'b1, BEST_MSG);

        $display("[TB] collision and point together");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        points(50);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("high50", 64'(bus.high_bcd), 64'(12'h050));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        points(41);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkAll("coll+point", 2'd2, 12'h041, 12'h050, 1'b0, LOSER_MSG);

        $display("[TB] blink");
        for (int j = 1; j < 12; j++) begin
            tick();
            checkOutput($sformatf("blink%0d hex", j), 64'(bus.hex_out),
                        ((j / 4) % 2 == 0) ? 64'(LOSER_MSG) : 64'({BL, D4, D1, BL, BL, BL}));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("restart", 2'd1, 12'h000, 12'h050, 1'b0, SC0);

        $display("[TB] clear_high and async reset");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        points(5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        points(3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("clr in play", 2'd1, 12'h003, 12'h005, 1'b0, SC1 & 42'h0 | {BL, BL, D3, BL, BL, BL});
        #2;
        reset = 1'b1;
        #1;
        checkAll("async reset", 2'd0, 12'h000, 12'h000, 1'b0, START_MSG);
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        points(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkAll("over high1", 2'd2, 12'h001, 12'h001, 1'b1, BEST_MSG);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("clr in over", 2'd2, 12'h001, 12'h000, 1'b1, BEST_MSG);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
